// File: rtl/mips_memory_if.sv
// Processor instruction/data ports plus loader stream, as seen by the memory.
interface mips_memory_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        data_rd_wr;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        mem_ready;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] load_count;

  modport master (
    output instr_addr, data_rd_wr, data_addr, data_out, load_valid, load_addr, load_data,
    input  instr_in, data_in, load_ready, mem_ready, fault, fault_addr, load_count
  );

  modport slave (
    input  instr_addr, data_rd_wr, data_addr, data_out, load_valid, load_addr, load_data,
    output instr_in, data_in, load_ready, mem_ready, fault, fault_addr, load_count
  );
endinterface

// File: rtl/mips_memory.sv
// Word-addressed unified memory with registered read-first ports, a loader
// stream, optional post-reset clearing and a sticky access-fault capture.
module mips_memory #(
  parameter logic [31:0] base_addr      = 32'h0000_0000,
  parameter int          depth_words    = 1024,
  parameter bit          clear_on_reset = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mips_memory_if.slave bus
);

  localparam int          aw        = $clog2(depth_words);
  localparam logic [32:0] base_ext  = {1'b0, base_addr};
  localparam logic [32:0] limit_ext = base_ext + 33'(depth_words) * 33'd4;

  localparam logic [0:0] st_clear = 1'b0;
  localparam logic [0:0] st_ready = 1'b1;

  // Window bounds are 33-bit so a window ending exactly at 2^32 still works.
  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= base_ext) && ({1'b0, addr} < limit_ext);
  endfunction

  function automatic logic [aw-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - base_addr;
    return aw'(offset >> 2);
  endfunction

  logic [0:0]    state;
  logic [aw-1:0] clear_idx;
  logic [31:0]   mem [depth_words];
  logic [31:0]   instr_q, data_q, fault_addr_q;
  logic [15:0]   load_count_q;
  logic          fault_q;

  logic is_ready, d_in, d_aligned, l_in, l_aligned;
  logic proc_wr, load_rdy, load_acc, load_wr, proc_fault, load_fault;

  always_comb begin
    is_ready   = (state == st_ready) && !reset;
    d_in       = in_range(bus.data_addr);
    d_aligned  = (bus.data_addr[1:0] == 2'b00);
    l_in       = in_range(bus.load_addr);
    l_aligned  = (bus.load_addr[1:0] == 2'b00);
    proc_wr    = is_ready && !bus.data_rd_wr && d_in && d_aligned;
    // Any in-range processor write, even a misaligned one, blocks the loader.
    load_rdy   = is_ready && !(!bus.data_rd_wr && d_in);
    load_acc   = bus.load_valid && load_rdy;
    load_wr    = load_acc && l_in && l_aligned;
    proc_fault = is_ready && (bus.data_rd_wr ? !d_in : !(d_in && d_aligned));
    load_fault = load_acc && !(l_in && l_aligned);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= clear_on_reset ? st_clear : st_ready;
      clear_idx <= '0;
    end else if (state == st_clear) begin
      if (clear_idx == aw'(depth_words - 1)) state <= st_ready;
      clear_idx <= clear_idx + aw'(1);
    end
  end

  // NOTE: the array has no reset branch; zeroing is done word-by-word in
  // CLEAR, which keeps it mappable to a RAM macro with one write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == st_clear)  mem[clear_idx]              <= '0;
      else if (proc_wr)       mem[word_idx(bus.data_addr)] <= bus.data_out;
      else if (load_wr)       mem[word_idx(bus.load_addr)] <= bus.load_data;
    end
  end

  // NOTE: registered reads sample the array before this edge's write lands,
  // giving read-first behaviour on both ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      instr_q <= (state == st_ready && in_range(bus.instr_addr))
                 ? mem[word_idx(bus.instr_addr)] : '0;
      data_q  <= (state == st_ready && d_in) ? mem[word_idx(bus.data_addr)] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      load_count_q <= '0;
    end else begin
      if (!fault_q && (proc_fault || load_fault)) begin
        fault_q      <= 1'b1;
        fault_addr_q <= proc_fault ? bus.data_addr : bus.load_addr;
      end
      if (load_acc && load_count_q != 16'hFFFF) load_count_q <= load_count_q + 16'd1;
    end
  end

  assign bus.instr_in   = instr_q;
  assign bus.data_in    = data_q;
  assign bus.load_ready = load_rdy;
  assign bus.mem_ready  = is_ready;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_mips_memory.sv
// Bench for mips_memory: clearing and non-clearing instances share stimulus.
module tb_mips_memory;

  typedef struct {
    logic        rd_wr;
    logic [31:0] daddr, dout, iaddr;
    logic        lvalid;
    logic [31:0] laddr, ldata;
    logic        exp_ready;
    logic [31:0] exp_instr, exp_data;
    logic        exp_fault;
    logic [31:0] exp_faddr;
    logic [15:0] exp_count;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] instr, data;
    logic        fault;
    logic [31:0] faddr;
    logic [15:0] count;
  } exp_t;

  logic clk, rst_a, rst_b;
  logic        rd_wr, lvalid;
  logic [31:0] daddr, dout, iaddr, laddr, ldata;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  mips_memory_if if_a ();
  mips_memory_if if_b ();

  assign if_a.data_rd_wr = rd_wr;  assign if_b.data_rd_wr = rd_wr;
  assign if_a.data_addr  = daddr;  assign if_b.data_addr  = daddr;
  assign if_a.data_out   = dout;   assign if_b.data_out   = dout;
  assign if_a.instr_addr = iaddr;  assign if_b.instr_addr = iaddr;
  assign if_a.load_valid = lvalid; assign if_b.load_valid = lvalid;
  assign if_a.load_addr  = laddr;  assign if_b.load_addr  = laddr;
  assign if_a.load_data  = ldata;  assign if_b.load_data  = ldata;

  mips_memory #(.base_addr(32'h1000), .depth_words(16), .clear_on_reset(1'b1))
    dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  mips_memory #(.base_addr(32'h1000), .depth_words(16), .clear_on_reset(1'b0))
    dut_b (.clk(clk), .reset(rst_b), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] da, input logic [31:0] dv,
                       input logic [31:0] ia, input logic lv, input logic [31:0] la,
                       input logic [31:0] ld);
    rd_wr = r; daddr = da; dout = dv; iaddr = ia; lvalid = lv; laddr = la; ldata = ld;
  endtask

  task automatic idle();
    drive(1'b1, 32'h1008, 32'h0, 32'h1008, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] da, input logic [31:0] dv,
                              input logic [31:0] ia, input logic lv, input logic [31:0] la,
                              input logic [31:0] ld, input logic er, input logic [31:0] ei,
                              input logic [31:0] ed, input logic ef, input logic [31:0] efa,
                              input logic [15:0] ec);
    vec_t v;
    v.rd_wr = r; v.daddr = da; v.dout = dv; v.iaddr = ia; v.lvalid = lv;
    v.laddr = la; v.ldata = ld; v.exp_ready = er; v.exp_instr = ei; v.exp_data = ed;
    v.exp_fault = ef; v.exp_faddr = efa; v.exp_count = ec;
    return v;
  endfunction

  // Drive one cycle on instance A, check load_ready now and the rest after the edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    drive(v.rd_wr, v.daddr, v.dout, v.iaddr, v.lvalid, v.laddr, v.ldata);
    #1;
    check({name, " load_ready"}, 32'(if_a.load_ready), 32'(v.exp_ready));
    e.name = name; e.instr = v.exp_instr; e.data = v.exp_data;
    e.fault = v.exp_fault; e.faddr = v.exp_faddr; e.count = v.exp_count;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " instr_in"},   if_a.instr_in,         e.instr);
    check({e.name, " data_in"},    if_a.data_in,          e.data);
    check({e.name, " fault"},      32'(if_a.fault),       32'(e.fault));
    check({e.name, " fault_addr"}, if_a.fault_addr,       e.faddr);
    check({e.name, " load_count"}, 32'(if_a.load_count),  32'(e.count));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " instr_in"},   if_a.instr_in,        32'h0);
    check({name, " data_in"},    if_a.data_in,         32'h0);
    check({name, " mem_ready"},  32'(if_a.mem_ready),  32'h0);
    check({name, " load_ready"}, 32'(if_a.load_ready), 32'h0);
    check({name, " fault"},      32'(if_a.fault),      32'h0);
    check({name, " fault_addr"}, if_a.fault_addr,      32'h0);
    check({name, " load_count"}, 32'(if_a.load_count), 32'h0);
    check({name, " B mem_ready"}, 32'(if_b.mem_ready), 32'h0);
  endtask

  vec_t vecs[19];
  int   n;

  initial begin
    //        rd    daddr         dout          iaddr         lv    laddr         ldata         rdy   instr         data          flt   faddr         cnt
    vecs[0]  = mk(1'b1, 32'h1004, 32'h0,        32'h1000, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd0);
    vecs[1]  = mk(1'b1, 32'h1010, 32'h0,        32'h1004, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd0);
    vecs[2]  = mk(1'b1, 32'h1004, 32'h0,        32'h1000, 1'b1, 32'h1008, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd1);
    vecs[3]  = mk(1'b1, 32'h1008, 32'h0,        32'h100A, 1'b0, 32'h0,    32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,    16'd1);
    vecs[4]  = mk(1'b0, 32'h1008, 32'h12345678, 32'h1008, 1'b1, 32'h100C, 32'h55555555, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,    16'd1);
    vecs[5]  = mk(1'b1, 32'h1008, 32'h0,        32'h1009, 1'b0, 32'h0,    32'h0,        1'b1, 32'h12345678, 32'h12345678, 1'b0, 32'h0,    16'd1);
    vecs[6]  = mk(1'b1, 32'h100C, 32'h0,        32'h100C, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd1);
    vecs[7]  = mk(1'b1, 32'h103C, 32'h0,        32'h1000, 1'b1, 32'h103C, 32'h0F0F0F0F, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd2);
    vecs[8]  = mk(1'b1, 32'h103C, 32'h0,        32'h103C, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 32'h0,    16'd2);
    vecs[9]  = mk(1'b1, 32'h1000, 32'h0,        32'h1040, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd2);
    vecs[10] = mk(1'b1, 32'h1000, 32'h0,        32'h0FFC, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 32'h0,    16'd2);
    vecs[11] = mk(1'b0, 32'h1042, 32'h77777777, 32'h1000, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b1, 32'h1042, 16'd2);
    vecs[12] = mk(1'b0, 32'h1005, 32'h99999999, 32'h1004, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h1042, 16'd2);
    vecs[13] = mk(1'b1, 32'h1004, 32'h0,        32'h1005, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        32'h0,        1'b1, 32'h1042, 16'd2);
    vecs[14] = mk(1'b1, 32'h1040, 32'h0,        32'h1008, 1'b0, 32'h0,    32'h0,        1'b1, 32'h12345678, 32'h0,        1'b1, 32'h1042, 16'd2);
    vecs[15] = mk(1'b1, 32'h1008, 32'h0,        32'h1008, 1'b1, 32'h1009, 32'h11111111, 1'b1, 32'h12345678, 32'h12345678, 1'b1, 32'h1042, 16'd3);
    vecs[16] = mk(1'b1, 32'h1008, 32'h0,        32'h1008, 1'b0, 32'h0,    32'h0,        1'b1, 32'h12345678, 32'h12345678, 1'b1, 32'h1042, 16'd3);
    vecs[17] = mk(1'b1, 32'h1008, 32'h0,        32'h1000, 1'b1, 32'h1008, 32'hDEADBEEF, 1'b1, 32'h0,        32'h12345678, 1'b1, 32'h1042, 16'd4);
    vecs[18] = mk(1'b1, 32'h1008, 32'h0,        32'h1008, 1'b0, 32'h0,    32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h1042, 16'd4);

    rst_a = 1'b1; rst_b = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset hold");

    // Release and count the clear phase; writes and stray reads meanwhile must be ignored.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin rst_a = 1'b0; rst_b = 1'b0; end
      if (i >= 2 && i <= 5) drive(1'b1, 32'h2000, 32'h0, 32'h1000, 1'b1, 32'h1000, 32'h1);
      else if (i >= 8)      drive(1'b0, 32'h1010, 32'hBAD0BAD0, 32'h1000, 1'b0, 32'h0, 32'h0);
      else                  drive(1'b1, 32'h1004, 32'h0, 32'h1000, 1'b0, 32'h0, 32'h0);
      #1;
      check($sformatf("clear cyc%0d mem_ready", i), 32'(if_a.mem_ready), 32'h0);
      if (i == 5)  check("clear load_ready", 32'(if_a.load_ready), 32'h0);
      if (i == 10) check("clear data_in", if_a.data_in, 32'h0);
    end
    @(negedge clk);
    idle();
    #1;
    check("clear done mem_ready", 32'(if_a.mem_ready), 32'h1);

    for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset both instances: A wipes, B keeps its contents.
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check_reset_outputs("reset again");
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;
    check("B kept data_in",   if_b.data_in,          32'hDEADBEEF);
    check("B kept instr_in",  if_b.instr_in,         32'hDEADBEEF);
    check("B load_count",     32'(if_b.load_count),  32'h0);
    check("B fault",          32'(if_b.fault),       32'h0);
    check("B mem_ready",      32'(if_b.mem_ready),   32'h1);
    n = 1;
    while (!if_a.mem_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("A reclear cycles", 32'(n), 32'd16);

    apply(mk(1'b1, 32'h1008, 32'h0, 32'h1010, 1'b0, 32'h0, 32'h0,
             1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 16'd0), "wiped");

    // Coinciding processor and loader faults: processor address wins.
    apply(mk(1'b0, 32'h2000, 32'h0, 32'h1000, 1'b1, 32'h3000, 32'h5,
             1'b1, 32'h0, 32'h0, 1'b1, 32'h2000, 16'd1), "prio");
    check("B prio fault",      32'(if_b.fault),      32'h1);
    check("B prio fault_addr", if_b.fault_addr,      32'h2000);
    check("B prio load_count", 32'(if_b.load_count), 32'h1);
    apply(mk(1'b1, 32'h1000, 32'h0, 32'h1000, 1'b1, 32'h1003, 32'h1,
             1'b1, 32'h0, 32'h0, 1'b1, 32'h2000, 16'd2), "sticky");

    // Reset A in the middle of clearing: clearing restarts from word 0.
    @(negedge clk);
    rst_a = 1'b1;
    idle();
    @(negedge clk);
    rst_a = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mid-clear mem_ready", 32'(if_a.mem_ready), 32'h0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!if_a.mem_ready && n < 40);
    check("restart clear cycles", 32'(n), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_memory.md
MIPS_MEMORY -- requirements
Module: mips_memory

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  base_addr, 32'h0000_0000, byte address of word 0.
  depth_words, 1024, number of 32-bit words; power of two, >=4.
  clear_on_reset, 1, if 1, zero all words after reset; if 0, contents are kept.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock; all state changes on its rising edge.
  reset  in  1  synchronous, active-high reset.
  instr_addr  in  32  instruction fetch byte address.
  instr_in  out  32  fetched instruction word.
  data_rd_wr  in  1  1 = read, 0 = write.
  data_addr  in  32  data byte address.
  data_out  in  32  write data from processor.
  data_in  out  32  read data to processor.
  load_valid  in  1  loader word offered.
  load_ready  out  1  loader word can be accepted.
  load_addr  in  32  loader byte address.
  load_data  in  32  loader word.
  mem_ready  out  1  clear done; memory serviceable.
  fault  out  1  sticky access-fault flag.
  fault_addr  out  32  address of the first fault.
  load_count  out  16  accepted loader words, saturating.

Function
REQ-003 Word index SHALL be (addr - base_addr) >> 2; an address is in range iff base_addr <= addr < base_addr + 4*depth_words, compared in 33 bits so the window may not wrap past 2^32.
REQ-004 The state machine SHALL have states CLEAR and READY; reset enters CLEAR with clear_idx=0 if clear_on_reset=1, else READY.
REQ-005 In CLEAR, the block SHALL write 0 to word clear_idx each cycle and increment it; after writing word depth_words-1 it SHALL enter READY, so mem_ready rises exactly depth_words cycles after reset deasserts.
REQ-006 In CLEAR, instr_in and data_in SHALL read 0, processor writes SHALL be ignored and load_ready SHALL be 0.
REQ-007 Reads SHALL be registered: instr_in and data_in SHALL present the word addressed in cycle N during cycle N+1, with 1-cycle latency on both ports.
REQ-008 An out-of-range read SHALL return 32'h0 on the next cycle.
REQ-009 instr_addr[1:0] SHALL be ignored.
REQ-010 In READY, when data_rd_wr=0 and data_addr is in range, the block SHALL write data_out to the indexed word at the clock edge; repeated identical writes over consecutive cycles are legal and idempotent.
REQ-011 Reads SHALL be read-first: a read of a word written in the same cycle (either port) SHALL return the old value, with the new value one cycle later.
REQ-012 load_ready SHALL equal (state==READY) && !(data_rd_wr==0 && data_addr in range), so processor writes have priority.
REQ-013 A loader word SHALL be accepted iff load_valid && load_ready at the edge; it writes load_data to word(load_addr) if in range, and load_count increments saturating at 16'hFFFF.
REQ-014 A fault event SHALL be any of the following in READY:
  - processor write out of range or with data_addr[1:0] != 0;
  - processor read (data_rd_wr=1) out of range;
  - accepted loader word out of range or misaligned.
REQ-015 Misaligned or out-of-range writes SHALL NOT modify memory.
REQ-016 On the first fault event the block SHALL set fault=1 and capture the offending address into fault_addr; later faults SHALL leave both unchanged until reset.
REQ-017 If processor and loader faults coincide in the same cycle, fault_addr SHALL take the processor address.
REQ-018 instr_addr out of range SHALL NOT raise fault.

Reset
REQ-019 While reset=1, the block SHALL drive instr_in=0, data_in=0, mem_ready=0, load_ready=0, fault=0, fault_addr=0 and load_count=0.
REQ-020 Reset asserted mid-CLEAR SHALL restart clearing at index 0.
REQ-021 Reset asserted in READY with clear_on_reset=1 SHALL wipe all contents again; with clear_on_reset=0, contents SHALL persist.
REQ-022 Reset SHALL take priority over every simultaneous write or load.

Verification
REQ-023 depth_words=16, base_addr=32'h1000: release reset -> mem_ready=0 for 16 cycles, 1 on cycle 17; read 32'h1004 -> data_in=0.
REQ-024 Loader writes 32'hDEADBEEF @32'h1008 -> load_count=1; then instr_addr=32'h100A -> instr_in=32'hDEADBEEF one cycle later.
REQ-025 data_rd_wr=0, data_addr=32'h1008, data_out=32'h12345678 with load_valid=1 in the same cycle -> load_ready=0, load not accepted; a same-cycle read returns 32'hDEADBEEF, the next cycle returns 32'h12345678.
REQ-026 Write to 32'h1042 (out of range) then 32'h1005 (misaligned) -> memory unchanged, fault=1, fault_addr=32'h0000_1042.
REQ-027 Reset after step REQ-024, then wait 16 cycles -> read 32'h1008 returns 0, load_count=0, fault=0; repeat with clear_on_reset=0 -> read returns 32'hDEADBEEF on the cycle after reset.
REQ-028 Assert reset at clear_idx=7 -> mem_ready rises 16 cycles after the second reset release.
